// File: rtl/edge_cnt_pkg.sv
// Shared encodings for the multi-channel edge counter.
// Build option: define EDGE_CNT_SYNC_EN to put a 2-flop synchronizer in front of each channel.
package edge_cnt_pkg;

    // Global edge-select encodings
    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // Per-channel level tracker states
    typedef enum logic [1:0] {
        ST_UNK = 2'b00,
        ST_LO  = 2'b01,
        ST_HI  = 2'b10
    } state_e;

    // Turn raw rise/fall detections into a count request for the selected mode
    function automatic logic edge_qualify(input logic [1:0] mode,
                                          input logic       rise,
                                          input logic       fall);
        logic q;
        q = 1'b0;
        case (mode)
            MODE_RISE: q = rise;
            MODE_FALL: q = fall;
            MODE_BOTH: q = rise | fall;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/edge_counter_chan.sv
// One trigger channel: optional input synchronizer, level-tracking FSM, counter and sticky
// overflow flag. Build option: EDGE_CNT_SYNC_EN adds a 2-flop synchronizer (+2 cycles latency).
module edge_counter_chan
    import edge_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit          SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    logic             s;        // sampled trigger level seen by the FSM
    logic             fsm_en;   // low while the synchronizer is still filling after reset
    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             ovf_q;
    logic             rise;
    logic             fall;
    logic             qual;

`ifdef EDGE_CNT_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] warm_q;

    // Two-stage synchronizer plus a matching warm-up shift so the FSM ignores stale sync data
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            warm_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], trig};
            warm_q <= {warm_q[0], 1'b1};
        end
    end

    assign s      = sync_q[1];
    assign fsm_en = warm_q[1];
`else
    assign s      = trig;
    assign fsm_en = 1'b1;
`endif

    // Level tracker: follows the input in every mode; UNK is left without reporting an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNK;
        end else if (!fsm_en) begin
            state_q <= ST_UNK;
        end else begin
            case (state_q)
                ST_UNK:  state_q <= s ? ST_HI : ST_LO;
                ST_LO:   state_q <= s ? ST_HI : ST_LO;
                ST_HI:   state_q <= s ? ST_HI : ST_LO;
                default: state_q <= ST_UNK;
            endcase
        end
    end

    // Edge detection from the current state and the sampled level
    always_comb begin
        rise = 1'b0;
        fall = 1'b0;
        if (fsm_en) begin
            rise = (state_q == ST_LO) && s;
            fall = (state_q == ST_HI) && !s;
        end
        qual = edge_qualify(mode, rise, fall);
    end

    // Counter and sticky overflow; a clear in the same cycle as an edge drops that edge
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (qual) begin
            if (count_q == COUNT_MAX) begin
                count_q <= SAT ? COUNT_MAX : '0;
                ovf_q   <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/edge_counter_multi.sv
// Multi-channel trigger-edge counter: CHANNELS independent edge_counter_chan instances
// sharing the global edge-select mode. Build option: EDGE_CNT_SYNC_EN (see channel).
module edge_counter_multi
    import edge_cnt_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter bit          SAT      = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       trig,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       ovf
);

    // One channel per trigger bit; count packed with channel i at [i*WIDTH +: WIDTH]
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        edge_counter_chan #(
            .WIDTH (WIDTH),
            .SAT   (SAT)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .trig  (trig[i]),
            .mode  (mode),
            .clr   (clr[i]),
            .count (count[i*WIDTH +: WIDTH]),
            .ovf   (ovf[i])
        );
    end

endmodule

// File: tb/tb_edge_counter_multi.sv
// Directed bench for edge_counter_multi: a wrapping instance and a saturating instance
// share the same stimulus; expected values are hand-computed.
module tb_edge_counter_multi;
    import edge_cnt_pkg::*;

`ifdef EDGE_CNT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  trig;
    logic [1:0]  mode;
    logic [3:0]  clr;
    logic [31:0] count_a;
    logic [31:0] count_b;
    logic [3:0]  ovf_a;
    logic [3:0]  ovf_b;

    int checks = 0;
    int errors = 0;

    edge_counter_multi #(.WIDTH(8), .CHANNELS(4), .SAT(1'b0)) dut_wrap (
        .clk   (clk),
        .rst   (rst),
        .trig  (trig),
        .mode  (mode),
        .clr   (clr),
        .count (count_a),
        .ovf   (ovf_a)
    );

    edge_counter_multi #(.WIDTH(8), .CHANNELS(4), .SAT(1'b1)) dut_sat (
        .clk   (clk),
        .rst   (rst),
        .trig  (trig),
        .mode  (mode),
        .clr   (clr),
        .count (count_b),
        .ovf   (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        trig = 4'b0001;
        mode = MODE_RISE;
        clr  = 4'b0000;
        tick(3);
        check("reset_count_a", count_a, 32'd0);
        check("reset_ovf_a", {28'd0, ovf_a}, 32'd0);
        check("reset_count_b", count_b, 32'd0);

        // 1: level high at reset is not an edge
        rst = 1'b0;
        tick(5 + LAT);
        check("t1_count0_no_edge", {24'd0, count_a[7:0]}, 32'd0);

        // 2: three 1-cycle pulses on ch1, rising mode
        for (int p = 0; p < 3; p++) begin
            trig[1] = 1'b1; tick(1);
            trig[1] = 1'b0; tick(1);
        end
        tick(LAT);
        check("t2_count1", {24'd0, count_a[15:8]}, 32'd3);
        check("t2_count_others", {count_a[31:16], count_a[7:0]}, 32'd0);
        check("t2_ovf", {28'd0, ovf_a}, 32'd0);

        // 3: falling on ch0 ignored in rising mode, then both/fall/hold
        trig[0] = 1'b0; tick(1 + LAT);
        check("t3_fall_in_rise_mode", {24'd0, count_a[7:0]}, 32'd0);
        mode = MODE_BOTH;
        trig[0] = 1'b1; tick(1);
        trig[0] = 1'b0; tick(1 + LAT);
        check("t3_both", {24'd0, count_a[7:0]}, 32'd2);
        mode = MODE_FALL;
        trig[0] = 1'b1; tick(1);
        trig[0] = 1'b0; tick(1 + LAT);
        check("t3_fall", {24'd0, count_a[7:0]}, 32'd3);
        mode = MODE_HOLD;
        trig[0] = 1'b1; tick(1);
        trig[0] = 1'b0; tick(1 + LAT);
        check("t3_hold", {24'd0, count_a[7:0]}, 32'd3);
        check("t3_ch1_untouched", {24'd0, count_a[15:8]}, 32'd3);

        // 4: 255 edges on ch2 via toggling in both-edge mode, then overflow
        mode = MODE_BOTH;
        for (int e = 0; e < 255; e++) begin
            trig[2] = ~trig[2]; tick(1);
        end
        tick(LAT);
        check("t4_pre_wrap", {24'd0, count_a[23:16]}, 32'd255);
        check("t4_pre_sat", {24'd0, count_b[23:16]}, 32'd255);
        check("t4_pre_ovf", {31'd0, ovf_a[2]}, 32'd0);
        trig[2] = ~trig[2]; tick(1 + LAT);
        check("t4_wrap_count", {24'd0, count_a[23:16]}, 32'd0);
        check("t4_wrap_ovf", {31'd0, ovf_a[2]}, 32'd1);
        check("t4_sat_count", {24'd0, count_b[23:16]}, 32'd255);
        check("t4_sat_ovf", {31'd0, ovf_b[2]}, 32'd1);
        trig[2] = ~trig[2]; tick(1 + LAT);
        check("t4_wrap_sticky_count", {24'd0, count_a[23:16]}, 32'd1);
        check("t4_wrap_sticky_ovf", {31'd0, ovf_a[2]}, 32'd1);
        check("t4_sat_hold", {24'd0, count_b[23:16]}, 32'd255);
        check("t4_other_ovf", {29'd0, ovf_a[3], ovf_a[1:0]}, 32'd0);

        // 5: bring ch0 to 7, then clear coinciding with a rising edge
        mode = MODE_RISE;
        for (int p = 0; p < 4; p++) begin
            trig[0] = 1'b1; tick(1);
            trig[0] = 1'b0; tick(1);
        end
        tick(LAT);
        check("t5_count0_7", {24'd0, count_a[7:0]}, 32'd7);
        trig[0] = 1'b1; tick(LAT);
        clr[0] = 1'b1; tick(1);
        clr[0] = 1'b0;
        check("t5_clr_wins_count", {24'd0, count_a[7:0]}, 32'd0);
        check("t5_clr_wins_ovf", {31'd0, ovf_a[0]}, 32'd0);
        tick(1);
        check("t5_edge_dropped", {24'd0, count_a[7:0]}, 32'd0);
        clr[2] = 1'b1; tick(1);
        clr[2] = 1'b0;
        check("t5_clr2_count", {24'd0, count_a[23:16]}, 32'd0);
        check("t5_clr2_ovf", {31'd0, ovf_a[2]}, 32'd0);
        check("t5_clr2_ovf_sat", {31'd0, ovf_b[2]}, 32'd0);

        // Simultaneous rising edges on all channels
        trig = 4'b0000; tick(1 + LAT);
        clr = 4'b1111; tick(1);
        clr = 4'b0000;
        trig = 4'b1111; tick(1 + LAT);
        check("all_chan_edge", count_a, 32'h01010101);
        check("all_chan_edge_sat", count_b, 32'h01010101);

        // 6: latency of one rising edge, then reset in mid-count
        trig[0] = 1'b0; tick(1 + LAT);
        trig[0] = 1'b1; tick(LAT);
        check("lat_before", {24'd0, count_a[7:0]}, 32'd1);
        tick(1);
        check("lat_after", {24'd0, count_a[7:0]}, 32'd2);
        rst = 1'b1; tick(1);
        check("mid_rst_count", count_a, 32'd0);
        check("mid_rst_count_sat", count_b, 32'd0);
        check("mid_rst_ovf", {24'd0, ovf_a, ovf_b}, 32'd0);
        rst = 1'b0;
        trig = 4'b0000;
        tick(2 + LAT);
        trig[1] = 1'b1; tick(1);
        trig[1] = 1'b0; tick(1 + LAT);
        check("post_rst_count1", {24'd0, count_a[15:8]}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
